// File: rtl/counter_sweep_ctrl_pkg.sv
// Shared types and constants for the counter sweep controller.
// The state encoding fits in 3 bits so it lines up with the VGA side's encodings.
package counter_sweep_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    RUN_FWD   = 3'd2,
    DWELL_TOP = 3'd3,
    RUN_BWD   = 3'd4,
    DWELL_BOT = 3'd5,
    DONE      = 3'd6
  } sweep_state_t;

  localparam int COUNTER_WIDTH          = 6;
  localparam int DEFAULT_TICKS_PER_STEP = 1;
  localparam int DEFAULT_DWELL_FRAMES   = 4;

  // The trip counter saturates rather than wrapping back to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/counter_sweep_ctrl_tick_prescaler.sv
// Counts tick pulses up to N and flags the N-th one with a same-cycle 'hit'.
// A synchronous clear zeroes the count so no partial progress survives a state change.
module tick_prescaler #(
  parameter int N = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic hit
);

  localparam int NN = (N < 1) ? 1 : N;
  localparam int CW = $clog2(NN + 1);

  logic [CW-1:0] count;

  // Combinational so the caller can act in the very cycle the N-th tick arrives.
  assign hit = tick && (count == CW'(NN - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || hit) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Ping-pong sweep controller for an up/down sprite counter, stepped by VGA frame ticks.
// Tracks a shadow position and flags any disagreement with the counter it drives.
module counter_sweep_ctrl
  import counter_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH          = COUNTER_WIDTH,
  parameter int TICKS_PER_STEP = DEFAULT_TICKS_PER_STEP,
  parameter int DWELL_FRAMES   = DEFAULT_DWELL_FRAMES,
  parameter int ROUND_TRIPS    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             frame_tick,
  input  logic [WIDTH-1:0] cnt_out,
  input  logic             cnt_finish,
  output logic             cnt_enable,
  output logic             cnt_forward,
  output logic             cnt_clear,
  output logic             busy,
  output logic             sweep_done,
  output logic             pos_err
);

  localparam logic [WIDTH-1:0] TOP = '1;

  sweep_state_t     state, next_state;
  logic [WIDTH-1:0] shadow;
  logic [15:0]      trips, trips_plus;
  logic             check_pending;
  logic             accept_start, trip_inc;
  logic             run_state, dwell_state, leaving;
  logic             step_hit, dwell_hit;
  logic             at_top, at_bot;

  assign run_state    = (state == RUN_FWD) || (state == RUN_BWD);
  assign dwell_state  = (state == DWELL_TOP) || (state == DWELL_BOT);
  assign leaving      = (next_state != state);
  assign at_top       = (shadow == TOP);
  assign at_bot       = (shadow == '0);
  assign trips_plus   = sat_inc16(trips);
  assign accept_start = start && !stop && ((state == IDLE) || (state == DONE));

  assign busy        = (state != IDLE) && (state != DONE);
  assign cnt_forward = !((state == DWELL_TOP) || (state == RUN_BWD));
  assign cnt_clear   = (state == CLEAR) && !stop;

  tick_prescaler #(.N(TICKS_PER_STEP)) u_step (
    .clk   (clk),
    .reset (reset),
    .clear (!run_state || leaving),
    .tick  (frame_tick && run_state),
    .hit   (step_hit)
  );

  tick_prescaler #(.N((DWELL_FRAMES < 1) ? 1 : DWELL_FRAMES)) u_dwell (
    .clk   (clk),
    .reset (reset),
    .clear (!dwell_state || leaving),
    .tick  (frame_tick && dwell_state),
    .hit   (dwell_hit)
  );

  // Stepping is refused at either end even if the counter never raises finish.
  always_comb begin
    next_state = state;
    cnt_enable = 1'b0;
    trip_inc   = 1'b0;
    if (stop) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start) next_state = CLEAR;
        CLEAR:      next_state = RUN_FWD;
        RUN_FWD: begin
          if (at_top) begin
            if (cnt_finish) next_state = (DWELL_FRAMES == 0) ? RUN_BWD : DWELL_TOP;
          end else if (step_hit) begin
            cnt_enable = 1'b1;
          end
        end
        DWELL_TOP:  if (dwell_hit) next_state = RUN_BWD;
        RUN_BWD: begin
          if (at_bot) begin
            if (cnt_finish) begin
              trip_inc = 1'b1;
              if ((ROUND_TRIPS != 0) && (trips_plus == 16'(ROUND_TRIPS)))
                next_state = DONE;
              else
                next_state = (DWELL_FRAMES == 0) ? RUN_FWD : DWELL_BOT;
            end
          end else if (step_hit) begin
            cnt_enable = 1'b1;
          end
        end
        DWELL_BOT:  if (dwell_hit) next_state = RUN_FWD;
        default:    next_state = IDLE;
      endcase
    end
  end

  // The counter's new value is only valid the cycle after a step, so compare then.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      shadow        <= '0;
      trips         <= '0;
      pos_err       <= 1'b0;
      check_pending <= 1'b0;
      sweep_done    <= 1'b0;
    end else begin
      state         <= next_state;
      sweep_done    <= (next_state == DONE) && (state != DONE);
      check_pending <= cnt_enable;
      if (accept_start) begin
        shadow  <= '0;
        trips   <= '0;
        pos_err <= 1'b0;
      end else begin
        if (cnt_enable) shadow <= (state == RUN_FWD) ? shadow + 1'b1 : shadow - 1'b1;
        if (trip_inc) trips <= trips_plus;
        if (check_pending && (cnt_out != shadow)) pos_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl driving a small saturating up/down counter.
// Uses a 4-bit counter, 2 ticks per step, 3-frame dwell and 2 round trips.
module tb_counter_sweep_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         frame_tick = 1'b0;
  logic         glitch = 1'b0;
  logic [W-1:0] ctr = '0;
  logic         cnt_finish;
  logic         cnt_enable, cnt_forward, cnt_clear, busy, sweep_done, pos_err;
  logic [5:0]   status;
  int           check_count = 0;
  int           error_count = 0;
  int           n;

  counter_sweep_ctrl #(
    .WIDTH          (W),
    .TICKS_PER_STEP (2),
    .DWELL_FRAMES   (3),
    .ROUND_TRIPS    (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .frame_tick  (frame_tick),
    .cnt_out     (ctr),
    .cnt_finish  (cnt_finish),
    .cnt_enable  (cnt_enable),
    .cnt_forward (cnt_forward),
    .cnt_clear   (cnt_clear),
    .busy        (busy),
    .sweep_done  (sweep_done),
    .pos_err     (pos_err)
  );

  always #5 clk = ~clk;

  // Counterpart counter: saturates at its ends; 'glitch' nudges it without a step.
  always @(posedge clk) begin
    if (cnt_clear) ctr <= '0;
    else if (cnt_enable) begin
      if (cnt_forward) begin
        if (ctr != 4'd15) ctr <= ctr + 4'd1;
      end else if (ctr != 4'd0) ctr <= ctr - 4'd1;
    end else if (glitch) ctr <= ctr + 4'd1;
  end

  assign cnt_finish = cnt_forward ? (ctr == 4'd15) : (ctr == 4'd0);
  assign status = {busy, cnt_enable, cnt_forward, cnt_clear, sweep_done, pos_err};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int n_ticks, output int en_count);
    en_count = 0;
    for (int i = 0; i < n_ticks; i++) begin
      @(negedge clk); frame_tick = 1'b1; #1;
      if (cnt_enable) en_count++;
      @(negedge clk); frame_tick = 1'b0; #1;
    end
  endtask

  task automatic idleCycle();
    @(negedge clk); #1;
  endtask

  task automatic startSweep(input string tag);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    checkOutput(tag, {30'd0, cnt_clear, busy}, 32'd3);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 checkOutput("reset_outputs", status, 6'b001000);
    @(negedge clk); reset = 1'b1;

    // Full first trip
    startSweep("start_clear");
    applyStimulus(1, n); checkOutput("first_tick_no_step", n, 0);
    applyStimulus(1, n); checkOutput("second_tick_step", n, 1);
    checkOutput("cnt_after_first_step", ctr, 1);
    applyStimulus(28, n); checkOutput("fwd_steps", n, 14);
    idleCycle();
    checkOutput("at_top", ctr, 15);
    checkOutput("dwell_top_backward", cnt_forward, 0);
    applyStimulus(4, n); checkOutput("dwell_top_no_step", n, 0);
    applyStimulus(1, n); checkOutput("first_bwd_step", n, 1);
    applyStimulus(28, n); checkOutput("bwd_steps", n, 14);
    idleCycle();
    checkOutput("at_bottom", ctr, 0);
    checkOutput("dwell_bot_status", status, 6'b101000);

    // Second trip ends in DONE
    applyStimulus(33, n); checkOutput("trip2_fwd_steps", n, 15);
    idleCycle();
    checkOutput("trip2_top", ctr, 15);
    applyStimulus(33, n); checkOutput("trip2_bwd_steps", n, 15);
    idleCycle();
    checkOutput("done_status", status, 6'b001010);
    checkOutput("done_cnt", ctr, 0);
    idleCycle();
    checkOutput("done_pulse_once", sweep_done, 0);
    applyStimulus(4, n); checkOutput("done_ignores_ticks", n, 0);

    // Stop mid-sweep
    startSweep("restart_from_done");
    applyStimulus(15, n); checkOutput("pre_stop_steps", n, 7);
    @(negedge clk); frame_tick = 1'b1; stop = 1'b1; #1;
    checkOutput("stop_no_step", cnt_enable, 0);
    @(negedge clk); frame_tick = 1'b0; stop = 1'b0; #1;
    checkOutput("stop_idle", busy, 0);
    checkOutput("stop_holds_cnt", ctr, 7);
    applyStimulus(2, n); checkOutput("idle_ignores_ticks", n, 0);
    startSweep("restart_after_stop");
    idleCycle();
    checkOutput("restart_cleared", ctr, 0);

    // Counter glitch detection
    applyStimulus(6, n); checkOutput("pre_glitch_steps", n, 3);
    @(negedge clk); glitch = 1'b1;
    @(negedge clk); glitch = 1'b0; #1;
    checkOutput("glitched_cnt", ctr, 4);
    checkOutput("no_err_before_step", pos_err, 0);
    applyStimulus(2, n);
    idleCycle();
    checkOutput("pos_err_set", pos_err, 1);
    applyStimulus(4, n);
    checkOutput("pos_err_sticky", pos_err, 1);
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0; #1;
    checkOutput("pos_err_survives_stop", pos_err, 1);
    startSweep("restart_after_glitch");
    checkOutput("pos_err_cleared", pos_err, 0);

    // Async reset in DWELL_BOT, then start+stop together
    applyStimulus(30, n); checkOutput("trip3_fwd_steps", n, 15);
    idleCycle();
    applyStimulus(33, n); checkOutput("trip3_bwd_steps", n, 15);
    idleCycle();
    checkOutput("dwell_bot_again", status, 6'b101000);
    applyStimulus(1, n);
    #1 reset = 1'b0;
    #1 checkOutput("async_reset_outputs", status, 6'b001000);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0; #1;
    checkOutput("start_stop_idle", {30'd0, busy, cnt_clear}, 0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
